// File: rtl/cam_pkg.sv
// Shared CAM definitions: readout FSM states, CAM mode codes
// and the index-width helper used by the tag reader.
package cam_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] RowxRow = 3'd1;
  localparam logic [2:0] ColxCol = 3'd2;
  localparam logic [2:0] COPY_B  = 3'd3;
  localparam logic [2:0] COPY_R  = 3'd4;
  localparam logic [2:0] COPY_A  = 3'd5;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cam_tag_reader_if.sv
// Result stream of the tag reader: valid/ready handshake
// carrying the matched row index and its captured contents.
interface cam_tag_reader_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder over the pending match mask.
// Purely combinational; any=0 means the mask is empty.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DATA_DEPTH = 16,
  parameter int IDX_W      = idx_width(DATA_DEPTH)
) (
  input  logic [DATA_DEPTH-1:0] i_req,
  output logic [IDX_W-1:0]      index,
  output logic                  any
);

  // Scan high to low so the lowest set bit wins last.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_tag_reader.sv
// Walks a latched CAM match vector, reading each hit row in
// ascending order. CAM_TAG_READER_COUNT_EN enables match_count.
module cam_tag_reader
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      start,
  input  logic [DATA_DEPTH-1:0]     tag_row,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH_CAM-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH_CAM:0]   match_count
);

  localparam int IDX_W = idx_width(DATA_DEPTH);

  state_t                    r_state;
  logic [DATA_DEPTH-1:0]     r_pending;
  logic [IDX_W-1:0]          r_idx;
  logic [ADDR_WIDTH_CAM-1:0] r_row_addr;
  logic [ADDR_WIDTH_CAM-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_done;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic [DATA_DEPTH-1:0] w_clr;

  cam_prio_enc #(
    .DATA_DEPTH (DATA_DEPTH),
    .IDX_W      (IDX_W)
  ) u_prio (
    .i_req (r_pending),
    .index (w_idx),
    .any   (w_any)
  );

  assign w_clr = DATA_DEPTH'(1) << r_idx;

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_idx      <= '0;
      r_row_addr <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pending <= tag_row;
            r_busy    <= 1'b1;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_any) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx      <= w_idx;
            r_row_addr <= ADDR_WIDTH_CAM'(w_idx);
            r_state    <= S_FETCH;
          end
        end
        // Row address has settled for a full cycle; capture the read.
        S_FETCH: begin
          r_out_data <= Q_out_row;
          r_out_addr <= ADDR_WIDTH_CAM'(r_idx);
          r_valid    <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            r_valid   <= 1'b0;
            r_pending <= r_pending & ~w_clr;
            r_state   <= S_SCAN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr_output_Row = r_row_addr;
  assign out_valid       = r_valid;
  assign out_addr        = r_out_addr;
  assign out_data        = r_out_data;
  assign busy            = r_busy;
  assign done            = r_done;

`ifdef CAM_TAG_READER_COUNT_EN
  logic [ADDR_WIDTH_CAM:0] w_pop;
  logic [ADDR_WIDTH_CAM:0] r_match;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      w_pop = w_pop + {{ADDR_WIDTH_CAM{1'b0}}, tag_row[i]};
    end
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_match <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_match <= w_pop;
    end
  end

  assign match_count = r_match;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_cam_tag_reader.sv
// Directed + randomized bench for cam_tag_reader against a
// behavioural CAM/readout model.
module tb_cam_tag_reader;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        start;
  logic [15:0] tag_row;
  logic [7:0]  q_row;
  logic [7:0]  row_addr;
  logic        busy;
  logic        done;
  logic [8:0]  match_count;

  cam_tag_reader_if #(.DW(8), .AW(8)) ifc ();

  cam_tag_reader #(
    .DATA_WIDTH     (8),
    .DATA_DEPTH     (16),
    .ADDR_WIDTH_CAM (8)
  ) dut (
    .clk             (clk),
    .rstIn           (rstIn),
    .start           (start),
    .tag_row         (tag_row),
    .Q_out_row       (q_row),
    .addr_output_Row (row_addr),
    .out_valid       (ifc.valid),
    .out_ready       (ifc.ready),
    .out_addr        (ifc.addr),
    .out_data        (ifc.data),
    .busy            (busy),
    .done            (done),
    .match_count     (match_count)
  );

  always #5 clk = ~clk;

  logic [7:0] cam_mem [16];

  always_comb begin
    q_row = 8'h00;
    if (row_addr < 8'd16) q_row = cam_mem[row_addr[3:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_a [$];
  int acc_d [$];
  int acc_c [$];
  int done_n;
  int done_cyc;
  int valid_n;

  always @(negedge clk) begin
    if (ifc.valid && ifc.ready) begin
      acc_a.push_back(int'(ifc.addr));
      acc_d.push_back(int'(ifc.data));
      acc_c.push_back(cyc + 1);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (ifc.valid) valid_n++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count(input logic [15:0] t);
`ifdef CAM_TAG_READER_COUNT_EN
    return $countones(t);
`else
    return 0;
`endif
  endfunction

  task automatic run(input logic [15:0] tag, input bit rnd,
                     input bit stall, input bit zero_after,
                     input bit mid_start, input string nm);
    int exp_q [$];
    int c0;
    int stall_left;
    int n;
    bit got;
    for (int i = 0; i < 16; i++) cam_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) if (tag[i]) exp_q.push_back(i);
    acc_a.delete();
    acc_d.delete();
    acc_c.delete();
    done_n     = 0;
    done_cyc   = 0;
    valid_n    = 0;
    stall_left = 5;
    got        = 1'b0;
    tag_row   = tag;
    start     = 1'b1;
    ifc.ready = 1'b1;
    c0 = cyc;
    tick();
    start   = 1'b0;
    tag_row = zero_after ? 16'h0000 : 16'($urandom);
    for (int k = 0; k < 600 && done_n == 0; k++) begin
      ifc.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && ifc.valid && acc_a.size() == 1 && stall_left > 0) begin
        ifc.ready = 1'b0;
        stall_left--;
        chk({nm, " stall addr"}, ifc.addr, exp_q[1]);
        chk({nm, " stall data"}, ifc.data, cam_mem[exp_q[1]]);
      end
      start = mid_start && ifc.valid && !got;
      if (start) got = 1'b1;
      tick();
    end
    start     = 1'b0;
    ifc.ready = 1'b1;
    chk({nm, " done seen"}, done_n, 1);
    n = exp_q.size();
    chk({nm, " result count"}, acc_a.size(), n);
    for (int i = 0; i < n && i < acc_a.size(); i++) begin
      chk({nm, " addr"}, acc_a[i], exp_q[i]);
      chk({nm, " data"}, acc_d[i], cam_mem[exp_q[i]]);
    end
    if (n == 0) begin
      chk({nm, " done cycle"}, done_cyc - c0, 2);
      chk({nm, " valid never"}, valid_n, 0);
    end else if (acc_c.size() > 0) begin
      chk({nm, " done after last"}, done_cyc - acc_c[$], 1);
      if (!rnd)
        chk({nm, " last accept cycle"}, acc_c[$] - (c0 + 1),
            3 * n + (stall ? 5 : 0));
    end
    tick();
    tick();
    tick();
    chk({nm, " done one pulse"}, done_n, 1);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " match_count"}, match_count, exp_count(tag));
  endtask

  initial begin
    logic [15:0] rt;
    rstIn     = 1'b0;
    start     = 1'b0;
    tag_row   = 16'h0000;
    ifc.ready = 1'b0;
    for (int i = 0; i < 16; i++) cam_mem[i] = 8'($urandom);
    #3;
    chk("rst valid", ifc.valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst row addr", row_addr, 0);
    chk("rst out addr", ifc.addr, 0);
    chk("rst out data", ifc.data, 0);
    chk("rst match", match_count, 0);
    tick();
    tick();
    rstIn = 1'b1;
    tick();

    run(16'h0000, 0, 0, 0, 0, "zero");
    run(16'h8421, 0, 0, 0, 0, "hot4");
    run(16'h8421, 0, 1, 0, 0, "stall");
    run(16'hFFFF, 0, 0, 0, 0, "ones");
    run(16'h0003, 0, 0, 1, 1, "tagchg");

    done_n  = 0;
    tag_row = 16'h8421;
    start   = 1'b1;
    ifc.ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && !(ifc.valid && ifc.addr == 8'd5); k++)
      tick();
    chk("midrst reached row5", ifc.addr, 5);
    #2;
    rstIn = 1'b0;
    #1;
    chk("midrst valid", ifc.valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst row addr", row_addr, 0);
    chk("midrst out addr", ifc.addr, 0);
    chk("midrst out data", ifc.data, 0);
    chk("midrst match", match_count, 0);
    tick();
    tick();
    chk("midrst no done", done_n, 0);
    rstIn = 1'b1;
    tick();
    run(16'h8421, 0, 0, 0, 0, "postrst");

    for (int r = 0; r < 4; r++) begin
      rt = 16'($urandom);
      run(rt, 1, 0, 0, 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
